// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    // First fetch address after reset when the top is not overridden.
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

    // Canonical no-op (addi x0, x0, 0), available to the core for bubbles.
    localparam logic [FETCH_XLEN-1:0] NOP = 32'h0000_0013;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    // Derived operating mode: DRAIN while stale responses are still due.
    typedef enum logic {
        MODE_STREAM = 1'b0,
        MODE_DRAIN  = 1'b1
    } fetch_mode_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear, used both as the prefetch buffer and
// as the in-order queue of request addresses awaiting their response.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  Depth = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [$clog2(Depth):0]     o_count,
    output T                           o_head
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    T                r_mem [Depth];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    // A pop on empty is ignored; a push on full is accepted only alongside a pop.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CntW'(Depth)) || w_do_pop);

    // Storage array: written on accepted push, no reset needed.
    // NOTE: the data array is deliberately not reset; occupancy is tracked by
    // the pointers and count, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (w_do_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over push and pop.
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(w_do_push) - CntW'(w_do_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests on a valid/grant
// port, pairs in-order responses with their PCs, buffers them in a prefetch
// FIFO and squashes the stream on a redirect from the core.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 RegBits = FETCH_XLEN,
    parameter int                 Depth   = 4,
    parameter logic [RegBits-1:0] ResetPc = FETCH_RESET_PC
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               mem_req_o,
    output logic [RegBits-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [RegBits-1:0] mem_rdata_i,
    output logic               instr_valid_o,
    output logic [RegBits-1:0] instr_o,
    output logic [RegBits-1:0] instr_pc_o,
    input  logic               instr_ready_i,
    input  logic               redirect_i,
    input  logic [RegBits-1:0] redirect_pc_i
);

    localparam int CntW = $clog2(Depth) + 1;

    logic [RegBits-1:0] r_fetch_pc;
    logic [CntW-1:0]    r_discard;

    logic [CntW-1:0]    w_buf_count;
    logic [CntW-1:0]    w_outstanding;
    logic [CntW:0]      w_credit_used;
    logic               w_req;
    logic               w_grant;
    logic               w_resp;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic               w_instr_valid;
    fetch_mode_e        w_mode;
    logic [RegBits-1:0] w_pcq_head;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;

    // Buffered plus in-flight words never exceed Depth, so the FIFO cannot overflow.
    assign w_credit_used = {1'b0, w_buf_count} + {1'b0, w_outstanding};

    // Request is held low while reset is asserted and during a redirect cycle.
    assign w_req   = rst_i && !redirect_i && (w_credit_used < (CntW + 1)'(Depth));
    assign w_grant = w_req && mem_gnt_i;

    // A response with nothing outstanding is spurious and ignored.
    assign w_resp  = mem_rvalid_i && (w_outstanding != '0);

    assign w_mode  = (r_discard == '0) ? MODE_STREAM : MODE_DRAIN;

    // Responses are dropped while draining stale data or in the redirect cycle itself.
    assign w_drop  = w_resp && (redirect_i || (w_mode == MODE_DRAIN));
    assign w_push  = w_resp && !w_drop;

    assign w_instr_valid = (w_buf_count != '0);
    assign w_pop         = w_instr_valid && instr_ready_i && !redirect_i;

    assign w_push_entry.pc    = w_pcq_head;
    assign w_push_entry.instr = mem_rdata_i;

    // Addresses of granted requests, in issue order; its occupancy is the
    // outstanding count. Never cleared: stale responses still retire entries.
    fetch_fifo #(
        .Depth (Depth),
        .T     (logic [RegBits-1:0])
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_grant),
        .i_data  (r_fetch_pc),
        .i_pop   (w_resp),
        .i_clear (1'b0),
        .o_count (w_outstanding),
        .o_head  (w_pcq_head)
    );

    // Prefetch buffer of {pc, instr} pairs handed to the core.
    fetch_fifo #(
        .Depth (Depth),
        .T     (fetch_entry_t)
    ) u_prefetch (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (redirect_i),
        .o_count (w_buf_count),
        .o_head  (w_head)
    );

    // Next fetch address: redirect target (word aligned) or advance on grant.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_fetch_pc <= ResetPc;
        end else if (redirect_i) begin
            r_fetch_pc <= redirect_pc_i & ~RegBits'(3);
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + RegBits'(4);
        end
    end

    // Stale-response counter: reloaded with the post-cycle outstanding count
    // on redirect (no grant can occur then), otherwise counts down on drops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_discard <= '0;
        end else if (redirect_i) begin
            r_discard <= w_outstanding - CntW'(w_resp);
        end else if (w_resp && (w_mode == MODE_DRAIN)) begin
            r_discard <= r_discard - CntW'(1);
        end
    end

    assign mem_req_o     = w_req;
    assign mem_addr_o    = r_fetch_pc;
    assign instr_valid_o = w_instr_valid;
    assign instr_o       = w_instr_valid ? w_head.instr : '0;
    assign instr_pc_o    = w_instr_valid ? w_head.pc    : '0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle core datapath and replaces its direct combinational instruction-memory read. It issues word-aligned fetch requests over a valid/grant memory port and tracks in-order responses. Fetched words land in a small prefetch FIFO, paired with their PC, and are handed to the core through a valid/ready handshake. A redirect from the core (branch, jump or JALR `pc_next`) flushes the FIFO and squashes in-flight responses.

## Interface
- `RegBits`, 32: instruction, address and PC width.
- `Depth`, 4: prefetch FIFO entries; also the cap on buffered plus in-flight words. Must be a power of two and at least 2.
- `ResetPc`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk_i` in 1: the single clock. All state changes on its rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `mem_req_o` out 1: fetch request valid.
- `mem_addr_o` out RegBits: fetch address, word aligned (`[1:0]`=0).
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: response valid. Responses return in order, at least 1 cycle after their grant.
- `mem_rdata_i` in RegBits: response instruction word.
- `instr_valid_o` out 1: FIFO head valid.
- `instr_o` out RegBits: FIFO head instruction. Reads 0 when `instr_valid_o`=0.
- `instr_pc_o` out RegBits: PC of `instr_o`. Reads 0 when `instr_valid_o`=0.
- `instr_ready_i` in 1: core consumes the head this cycle.
- `redirect_i` in 1: discard the stream and refetch.
- `redirect_pc_i` in RegBits: new fetch PC. Bits `[1:0]` are ignored (forced to 0).

## Operation
State:
- `fetch_pc`: next address to request.
- `outstanding`: granted, response not yet received; range 0..Depth.
- `discard`: stale responses still to drop; range 0..outstanding.
- FIFO: `count` entries, each holding {pc, instr}.

Request rules:
- `mem_req_o` = (`count` + `outstanding` < Depth) && !`redirect_i`.
- `mem_addr_o` = `fetch_pc`.
- Handshake: a grant (`mem_req_o` && `mem_gnt_i`) increments `outstanding` and advances `fetch_pc` by 4. Wrap-around at 2^RegBits is modulo, with no flag.
- The pc of each granted request is recorded in a pc queue of Depth entries. On response, that pc is paired with the returned word.

Response rules:
- `mem_rvalid_i` decrements `outstanding`.
- If `discard` > 0, the response is dropped and `discard` decrements.
- Otherwise {pc, `mem_rdata_i`} is pushed into the FIFO.
- The FIFO never overflows, because of the credit rule.
- `mem_rvalid_i` while `outstanding`=0 is ignored.

Pop rule: the head is removed when `instr_valid_o` && `instr_ready_i`.

Redirect, which has priority over every other event in the same cycle:
- The FIFO is emptied and any pop that cycle is void.
- `fetch_pc` is set to `{redirect_pc_i[RegBits-1:2],2'b00}`.
- `discard` is set to the post-cycle `outstanding`. That value includes any request granted this cycle; `mem_req_o` is 0 during redirect, so no new grant occurs. It excludes any response arriving this cycle, which is itself dropped.
- Back-to-back redirects: each redirect recomputes `discard` from the current `outstanding`, and the last PC wins.

Modes (derived, no explicit FSM register):
- STREAM when `discard`=0.
- DRAIN when `discard`>0. New requests may still issue in DRAIN; because responses are in order, the drop counter isolates stale data.

## Timing
- Reset, while `rst_i`=0: `mem_req_o`=0, `mem_addr_o`=ResetPc, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, and all counters are 0.
- The first cycle after reset deassertion has `mem_req_o`=1 at ResetPc.
- There is no bypass: a response pushed at edge N is visible on `instr_o` in the cycle after edge N.
- Redirect-to-first-valid latency, with a 1-cycle memory:
  - redirect in cycle R;
  - request and grant in cycle R+1;
  - rvalid in cycle R+2;
  - `instr_valid_o` in cycle R+3.
- Steady state with 1-cycle memory and `instr_ready_i`=1: one instruction per cycle.
- Reset asserted mid-operation clears all state immediately. Outstanding memory responses after release are the environment's responsibility; the memory is reset too.

## Structure
- `fetch_pkg`:
  - the `fetch_entry_t` struct {pc, instr};
  - the `FETCH_RESET_PC` default;
  - the `NOP` constant 32'h0000_0013.
- Sub-module `fetch_fifo`:
  - Depth-entry synchronous FIFO of `fetch_entry_t`;
  - interface: push, pop, clear, count, head;
  - asynchronous active-low reset.
- The in-order pc queue reuses `fetch_fifo`.

## Test plan
- Reset release, 1-cycle memory, core always ready → `instr_pc_o` sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, with instr matching memory.
- `instr_ready_i`=0 for 10 cycles → exactly 4 requests granted, then `mem_req_o`=0; FIFO holds PCs 0x0–0xC. Ready reasserted → no loss and no duplication.
- Redirect to 0x100 with 3 requests outstanding (3-cycle memory) → 3 responses dropped, and the next valid has `instr_pc_o`=0x100.
- Redirect in the same cycle as `mem_rvalid_i` and a pop → response dropped, FIFO empty next cycle, fetch resumes at the new PC.
- `redirect_pc_i`=0x103 → `mem_addr_o`=0x100.
- Wrap-around: start fetching at 0xFFFF_FFFC → the next address is 0x0.
- Reset asserted mid-stream → all outputs 0 in the same cycle, restart at ResetPc.
